// File: rtl/point_add_arbiter.sv
// point_add_arbiter
//   Shares one PointAdd unit (extended twisted-Edwards add/double) among
//   N_REQ requesters. Round-robin arbitration with an optional ownership lock
//   so one requester can chain back-to-back operations. Operands and mode
//   flags are latched at grant and held for the whole operation; the result
//   is registered and returned with a one-cycle done pulse to the owner.
// Ports:
//   i_clk, i_rst            clock, asynchronous active-high reset
//   i_req/i_lock            per-requester request and keep-ownership flags
//   i_doubling/i_initial    per-requester PointAdd mode flags
//   i_x1..i_t2              per-requester operands, requester k at [k*W +: W]
//   o_gnt/o_done            one-hot grant (combinational) / done (registered)
//   o_x3..o_t3              registered result, held until next capture
//   o_busy, o_err           unit owned / sticky protocol error
//   o_pa_*, i_pa_*          PointAdd start/mode/operand and result/finished
module point_add_arbiter #(
  parameter int N_REQ = 2,
  parameter int W     = 255
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [N_REQ-1:0]   i_req,
  input  logic [N_REQ-1:0]   i_lock,
  input  logic [N_REQ-1:0]   i_doubling,
  input  logic [N_REQ-1:0]   i_initial,
  input  logic [N_REQ*W-1:0] i_x1,
  input  logic [N_REQ*W-1:0] i_y1,
  input  logic [N_REQ*W-1:0] i_z1,
  input  logic [N_REQ*W-1:0] i_t1,
  input  logic [N_REQ*W-1:0] i_x2,
  input  logic [N_REQ*W-1:0] i_y2,
  input  logic [N_REQ*W-1:0] i_z2,
  input  logic [N_REQ*W-1:0] i_t2,
  output logic [N_REQ-1:0]   o_gnt,
  output logic [N_REQ-1:0]   o_done,
  output logic [W-1:0]       o_x3,
  output logic [W-1:0]       o_y3,
  output logic [W-1:0]       o_z3,
  output logic [W-1:0]       o_t3,
  output logic               o_busy,
  output logic               o_err,
  output logic               o_pa_start,
  output logic               o_pa_doubling,
  output logic               o_pa_initial,
  output logic [W-1:0]       o_pa_x1,
  output logic [W-1:0]       o_pa_y1,
  output logic [W-1:0]       o_pa_z1,
  output logic [W-1:0]       o_pa_t1,
  output logic [W-1:0]       o_pa_x2,
  output logic [W-1:0]       o_pa_y2,
  output logic [W-1:0]       o_pa_z2,
  output logic [W-1:0]       o_pa_t2,
  input  logic [W-1:0]       i_pa_x3,
  input  logic [W-1:0]       i_pa_y3,
  input  logic [W-1:0]       i_pa_z3,
  input  logic [W-1:0]       i_pa_t3,
  input  logic               i_pa_finished
);

  localparam int IW = (N_REQ > 2) ? 2 : 1;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_BUSY} state_t;

  state_t          r_state, w_state_nxt;
  logic [IW-1:0]   r_rr, r_owner, r_lock_owner;
  logic            r_lock_vld;
  logic [IW-1:0]   w_win_idx, w_rr_nxt;
  logic            w_win;
  int unsigned     w_k;
  logic [N_REQ-1:0] w_gnt;
  logic [W-1:0]    r_x1, r_y1, r_z1, r_t1, r_x2, r_y2, r_z2, r_t2;
  logic            r_dbl, r_ini;
  logic [W-1:0]    r_x3, r_y3, r_z3, r_t3;
  logic [N_REQ-1:0] r_done;
  logic            r_err;
  logic            w_active;

  // Winner selection. A valid lock blocks everyone else even when the lock
  // owner is not currently requesting.
  always_comb begin
    w_win     = 1'b0;
    w_win_idx = '0;
    w_k       = 0;
    if (r_lock_vld) begin
      w_win_idx = r_lock_owner;
      w_win     = i_req[r_lock_owner];
    end else begin
      for (int unsigned i = 0; i < N_REQ; i++) begin
        w_k = 32'(r_rr) + i;
        if (w_k >= N_REQ) w_k = w_k - N_REQ;
        if (!w_win && i_req[IW'(w_k)]) begin
          w_win     = 1'b1;
          w_win_idx = IW'(w_k);
        end
      end
    end
  end

  assign w_rr_nxt = (w_win_idx == IW'(N_REQ - 1)) ? '0 : w_win_idx + 1'b1;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_gnt       = '0;
    o_pa_start  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_win) begin
          w_gnt[w_win_idx] = 1'b1;
          w_state_nxt      = S_ISSUE;
        end
      end
      S_ISSUE: begin
        o_pa_start  = 1'b1;
        w_state_nxt = S_BUSY;
      end
      S_BUSY: begin
        if (i_pa_finished) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_rr         <= '0;
      r_owner      <= '0;
      r_lock_owner <= '0;
      r_lock_vld   <= 1'b0;
      r_x1 <= '0; r_y1 <= '0; r_z1 <= '0; r_t1 <= '0;
      r_x2 <= '0; r_y2 <= '0; r_z2 <= '0; r_t2 <= '0;
      r_dbl <= 1'b0; r_ini <= 1'b0;
      r_x3 <= '0; r_y3 <= '0; r_z3 <= '0; r_t3 <= '0;
      r_done <= '0;
      r_err  <= 1'b0;
    end else begin
      r_done <= '0;
      if (r_state == S_IDLE && w_win) begin
        r_x1    <= i_x1[w_win_idx*W +: W];
        r_y1    <= i_y1[w_win_idx*W +: W];
        r_z1    <= i_z1[w_win_idx*W +: W];
        r_t1    <= i_t1[w_win_idx*W +: W];
        r_x2    <= i_x2[w_win_idx*W +: W];
        r_y2    <= i_y2[w_win_idx*W +: W];
        r_z2    <= i_z2[w_win_idx*W +: W];
        r_t2    <= i_t2[w_win_idx*W +: W];
        r_dbl   <= i_doubling[w_win_idx];
        r_ini   <= i_initial[w_win_idx];
        r_owner <= w_win_idx;
        r_rr    <= w_rr_nxt;
      end
      // A finished pulse outside BUSY carries no valid result.
      if (r_state != S_BUSY && i_pa_finished) r_err <= 1'b1;
      if (r_state == S_BUSY && i_pa_finished) begin
        r_x3 <= i_pa_x3; r_y3 <= i_pa_y3; r_z3 <= i_pa_z3; r_t3 <= i_pa_t3;
        r_done[r_owner] <= 1'b1;
        r_lock_vld      <= i_lock[r_owner];
        r_lock_owner    <= r_owner;
      end
    end
  end

  assign w_active = (r_state != S_IDLE);

  assign o_gnt         = w_gnt;
  assign o_done        = r_done;
  assign o_x3          = r_x3;
  assign o_y3          = r_y3;
  assign o_z3          = r_z3;
  assign o_t3          = r_t3;
  assign o_busy        = w_active;
  assign o_err         = r_err;
  assign o_pa_doubling = w_active & r_dbl;
  assign o_pa_initial  = w_active & r_ini;
  assign o_pa_x1       = w_active ? r_x1 : '0;
  assign o_pa_y1       = w_active ? r_y1 : '0;
  assign o_pa_z1       = w_active ? r_z1 : '0;
  assign o_pa_t1       = w_active ? r_t1 : '0;
  assign o_pa_x2       = w_active ? r_x2 : '0;
  assign o_pa_y2       = w_active ? r_y2 : '0;
  assign o_pa_z2       = w_active ? r_z2 : '0;
  assign o_pa_t2       = w_active ? r_t2 : '0;

endmodule
